// File: rtl/pipebox.sv
// Elastic register pipeline of DEPTH valid/data stages with a combinational ready chain.
// Define PIPEBOX_OCC_EN to add the registered occupancy count port OCC.
(* whitebox *)
module pipebox #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             I_VLD,
  output logic             I_RDY,
  (* CLK_TO_Q = "CLK 10e-12" *)
  output logic [WIDTH-1:0] O,
  (* CLK_TO_Q = "CLK 10e-12" *)
  output logic             O_VLD,
  input  logic             O_RDY
`ifdef PIPEBOX_OCC_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] OCC
`endif
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [WIDTH-1:0] src    [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] drain, load;
  // Bit DEPTH stands for the downstream consumer so every stage uses the same rule.
  logic [DEPTH:0]   can_load;

  always_comb begin
    can_load        = '0;
    drain           = '0;
    can_load[DEPTH] = O_RDY;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      drain[k]    = valid_q[k] & can_load[k+1];
      can_load[k] = ~valid_q[k] | drain[k];
    end
  end

  assign I_RDY = can_load[0] & ~RST;

  always_comb begin
    src[0]  = I;
    load[0] = I_VLD & I_RDY;
    for (int k = 1; k < DEPTH; k++) begin
      src[k]  = data_q[k-1];
      load[k] = drain[k-1];
    end
    for (int k = 0; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k];
      data_d[k]  = data_q[k];
      if (load[k]) begin
        valid_d[k] = 1'b1;
        data_d[k]  = src[k];
      end else if (drain[k]) begin
        valid_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign O     = data_q[DEPTH-1];
  assign O_VLD = valid_q[DEPTH-1];

`ifdef PIPEBOX_OCC_EN
  logic [$clog2(DEPTH+1)-1:0] occ_q, occ_d;
  logic                       in_xfer, out_xfer;

  always_comb begin
    in_xfer  = I_VLD & I_RDY;
    out_xfer = drain[DEPTH-1];
    occ_d    = occ_q;
    if (in_xfer && !out_xfer) begin
      occ_d = occ_q + 1'b1;
    end else if (!in_xfer && out_xfer) begin
      occ_d = occ_q - 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign OCC = occ_q;
`endif

endmodule

// File: tb/tb_pipebox.sv
// Bench for pipebox: DEPTH=3 instance checked every cycle against a word-position model,
// plus a DEPTH=1 instance driven with directed vectors.
module tb_pipebox;
  localparam int D = 3;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] I, O;
  logic       I_VLD, I_RDY, O_VLD, O_RDY;
  logic [7:0] i1, o1;
  logic       i1_vld, i1_rdy, o1_vld, o1_rdy;
`ifdef PIPEBOX_OCC_EN
  logic [$clog2(D+1)-1:0] occ;
  logic [0:0]             occ1;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int cyc_n   = 0;

  // Model: in-flight words oldest first, with the stage index each one occupies.
  logic [7:0] mq_data[$];
  int         mq_pos[$];
  logic [7:0] out_log[$];
  int         out_cyc[$];

  always #5 CLK = ~CLK;

  pipebox #(.WIDTH(8), .DEPTH(D)) u_dut (
    .CLK(CLK), .RST(RST), .I(I), .I_VLD(I_VLD), .I_RDY(I_RDY),
    .O(O), .O_VLD(O_VLD), .O_RDY(O_RDY)
`ifdef PIPEBOX_OCC_EN
    , .OCC(occ)
`endif
  );

  pipebox #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .CLK(CLK), .RST(RST), .I(i1), .I_VLD(i1_vld), .I_RDY(i1_rdy),
    .O(o1), .O_VLD(o1_vld), .O_RDY(o1_rdy)
`ifdef PIPEBOX_OCC_EN
    , .OCC(occ1)
`endif
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Each word advances one stage if the stage ahead ends the cycle free; returns
  // whether stage 0 ends up free (i.e. the block is ready to accept).
  function automatic bit plan(input int pin[$], input bit ordy, output int pout[$],
                              output bit pop);
    int lim;
    int first;
    pout  = {};
    pop   = (pin.size() > 0) && (pin[0] == D - 1) && ordy;
    first = pop ? 1 : 0;
    lim   = D - 1;
    for (int i = first; i < pin.size(); i++) begin
      int np;
      np = (pin[i] + 1 <= lim) ? pin[i] + 1 : pin[i];
      pout.push_back(np);
      lim = np - 1;
    end
    return (pout.size() == 0) || (pout[pout.size()-1] > 0);
  endfunction

  always @(posedge CLK) begin
    int pn[$];
    bit pop, rdy;
    if (RST) begin
      mq_data.delete();
      mq_pos.delete();
    end else begin
      rdy = plan(mq_pos, O_RDY, pn, pop);
      if (pop) void'(mq_data.pop_front());
      mq_pos = pn;
      if (I_VLD && rdy) begin
        mq_data.push_back(I);
        mq_pos.push_back(0);
      end
    end
  end

  always @(negedge CLK) begin
    int pn[$];
    bit pop, exp_rdy, exp_vld;
    if (chk_en) begin
      exp_vld = (mq_pos.size() > 0) && (mq_pos[0] == D - 1);
      check("o_vld", O_VLD, exp_vld);
      if (exp_vld) check("o_data", O, mq_data[0]);
      exp_rdy = plan(mq_pos, O_RDY, pn, pop) && !RST;
      check("i_rdy", I_RDY, exp_rdy);
`ifdef PIPEBOX_OCC_EN
      check("occ", occ, mq_pos.size());
`endif
      if (O_VLD && O_RDY && !RST) begin
        out_log.push_back(O);
        out_cyc.push_back(cyc_n);
      end
    end
    cyc_n++;
  end

  task automatic cyc(input bit vld, input logic [7:0] d, input bit ordy, output bit acc);
    I_VLD = vld;
    I     = d;
    O_RDY = ordy;
    #7;
    acc = vld && I_RDY;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    bit         acc;
    int         w, edges, first_k, base, sent;
    logic [7:0] d;
    logic [7:0] sent_log[$];

    RST = 1'b1; I_VLD = 1'b1; I = 8'hAA; O_RDY = 1'b1;
    i1 = 8'h00; i1_vld = 1'b0; o1_rdy = 1'b0;
    @(posedge CLK);
    #2;
    chk_en = 1'b1;

    // Reset with a word presented: nothing accepted, outputs cleared.
    check("rst_irdy", I_RDY, 1'b0);
    check("rst_o", O, 8'h00);
    check("rst_ovld", O_VLD, 1'b0);
    cyc(1'b1, 8'hAA, 1'b1, acc);
    check("rst_acc", acc, 1'b0);
    RST = 1'b0;
    for (int c = 0; c < 5; c++) cyc(1'b0, 8'h00, 1'b1, acc);
    check("rst_no_emit", out_log.size(), 0);

    // Streaming 0x01..0x10 with the output always ready.
    base = out_log.size();
    w = 1; edges = 0; first_k = -1;
    for (int c = 0; c < 40; c++) begin
      cyc(w <= 16, 8'(w), 1'b1, acc);
      if (acc && w == 1) edges = 0;
      else edges++;
      if (O_VLD && first_k < 0) first_k = edges;
      if (acc) w++;
    end
    check("stream_latency", first_k, D - 1);
    check("stream_count", out_log.size() - base, 16);
    for (int j = 0; j < 16; j++) check("stream_order", out_log[base+j], 8'(j + 1));
    check("stream_rate", out_cyc[base+15] - out_cyc[base], 15);

    // Fill while stalled, then emit and accept on the same edge.
    base = out_log.size();
    cyc(1'b1, 8'h11, 1'b0, acc); check("fill_acc1", acc, 1'b1);
    cyc(1'b1, 8'h22, 1'b0, acc); check("fill_acc2", acc, 1'b1);
    cyc(1'b1, 8'h33, 1'b0, acc); check("fill_acc3", acc, 1'b1);
    check("full_irdy", I_RDY, 1'b0);
    check("full_o", O, 8'h11);
`ifdef PIPEBOX_OCC_EN
    check("full_occ", occ, 3);
`endif
    cyc(1'b1, 8'h44, 1'b1, acc);
    check("swap_acc", acc, 1'b1);
    check("swap_out", out_log.size() > base ? out_log[base] : 8'hFF, 8'h11);
    for (int c = 0; c < 6; c++) cyc(1'b0, 8'h00, 1'b1, acc);
    check("swap_count", out_log.size() - base, 4);
    check("swap_tail", out_log[out_log.size()-1], 8'h44);

    // Reset with two words in flight: both dropped.
    base = out_log.size();
    cyc(1'b1, 8'hAB, 1'b0, acc);
    cyc(1'b1, 8'hCD, 1'b0, acc);
    RST = 1'b1;
    cyc(1'b0, 8'h00, 1'b1, acc);
    RST = 1'b0;
    check("mid_rst_ovld", O_VLD, 1'b0);
`ifdef PIPEBOX_OCC_EN
    check("mid_rst_occ", occ, 0);
`endif
    for (int c = 0; c < 6; c++) cyc(1'b0, 8'h00, 1'b1, acc);
    check("mid_rst_dropped", out_log.size() - base, 0);

    // Random valid/ready traffic, scoreboarded against acceptance order.
    base = out_log.size();
    sent = 0;
    for (int c = 0; c < 20000 && sent < 1000; c++) begin
      d = 8'($urandom);
      cyc(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)), acc);
      if (acc) begin
        sent_log.push_back(d);
        sent++;
      end
    end
    check("rand_budget", sent, 1000);
    for (int c = 0; c < 8; c++) cyc(1'b0, 8'h00, 1'b1, acc);
    check("rand_count", out_log.size() - base, sent);
    for (int j = 0; j < sent && base + j < out_log.size(); j++) begin
      check("rand_order", out_log[base+j], sent_log[j]);
    end

    // DEPTH=1 instance: zero-latency visibility and back-to-back flow.
    I_VLD = 1'b0;
    i1 = 8'h5A; i1_vld = 1'b1; o1_rdy = 1'b0;
    #7;
    check("d1_irdy_empty", i1_rdy, 1'b1);
    @(posedge CLK);
    #2;
    check("d1_ovld", o1_vld, 1'b1);
    check("d1_o", o1, 8'h5A);
    check("d1_irdy_full", i1_rdy, 1'b0);
    o1_rdy = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      i1 = 8'(j);
      #7;
      check("d1_b2b_irdy", i1_rdy, 1'b1);
      @(posedge CLK);
      #2;
      check("d1_b2b_o", o1, 8'(j));
      check("d1_b2b_vld", o1_vld, 1'b1);
    end
    i1_vld = 1'b0;
    @(posedge CLK);
    #2;
    check("d1_drained", o1_vld, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipebox.md
PIPEBOX -- requirements
Module: pipebox

Interface
REQ-001 Parameter WIDTH, default 1, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, default 2, number of register stages; legal range 1..16.
REQ-003 CLK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous reset, active-high, sampled on CLK rising edge.
REQ-005 I  input  WIDTH  input data word.
REQ-006 I_VLD  input  1  input word valid.
REQ-007 I_RDY  output  1  block can accept a word this cycle.
REQ-008 O  output  WIDTH  output data word, driven from the last stage register.
REQ-009 O_VLD  output  1  output word valid.
REQ-010 O_RDY  input  1  downstream accepts the output word this cycle.
REQ-011 OCC  output  $clog2(DEPTH+1)  occupancy count; present only with PIPEBOX_OCC_EN (REQ-027).
REQ-012 Module SHALL carry the whitebox attribute; O and O_VLD SHALL carry a clock-to-Q timing attribute of 10e-12 so VPR sees registered paths.

Function
REQ-013 Each stage k (0..DEPTH-1) SHALL hold one data register and one valid bit; stage 0 is fed from I, stage DEPTH-1 drives O/O_VLD.
REQ-014 Input transfer occurs on a rising edge where I_VLD=1 and I_RDY=1; output transfer where O_VLD=1 and O_RDY=1.
REQ-015 Stage DEPTH-1 drains when it is valid and O_RDY=1; stage k<DEPTH-1 drains when it is valid and stage k+1 can load.
REQ-016 Stage k can load when it is empty or drains in the same cycle; I_RDY SHALL equal "stage 0 can load" (combinational ready chain from O_RDY).
REQ-017 On a drain without a matching load, a stage's valid bit SHALL clear; its data register MAY hold the stale value.
REQ-018 Throughput SHALL be one word per cycle when O_RDY is held at 1.
REQ-019 Latency: word accepted at edge t SHALL appear on O with O_VLD=1 after edge t+DEPTH-1 when no stall occurs (DEPTH=1: visible right after the accepting edge).
REQ-020 Words SHALL leave in acceptance order; no word is dropped or duplicated.
REQ-021 Full (all stages valid) with O_RDY=0: I_RDY=0, all stage contents held unchanged.
REQ-022 Full with O_RDY=1 and I_VLD=1: SHALL emit and accept in the same cycle; occupancy unchanged.
REQ-023 Bubbles: an empty stage between valid stages SHALL be collapsed as the upstream word advances into it, even while O_RDY=0.
REQ-024 O and O_VLD SHALL be pure register outputs; I_RDY is the only combinational output.

Reset
REQ-025 While RST=1 at a rising edge: all valid bits cleared, all data registers set to 0, OCC set to 0; following that edge O=0, O_VLD=0.
REQ-026 I_RDY SHALL be 0 while RST=1; transfers presented during reset are discarded; reset mid-operation drops all in-flight words.

Configuration
REQ-027 Macro PIPEBOX_OCC_EN: when defined, port OCC exists and holds a registered count = number of valid stages, +1 on input transfer only, -1 on output transfer only, unchanged on both or neither; never exceeds DEPTH.
REQ-028 Without PIPEBOX_OCC_EN, port OCC and its counter SHALL be absent; all other behaviour identical.

Verification (WIDTH=8, DEPTH=3)
REQ-029 Reset with I_VLD=1, I=0xAA -> O=0x00, O_VLD=0, I_RDY=0 during reset; no word emitted afterwards.
REQ-030 Stream 0x01..0x10 with O_RDY=1 -> first O_VLD after 3 cycles, 16 consecutive words in order, OCC steady at 3.
REQ-031 Push 0x11,0x22,0x33 with O_RDY=0 -> I_RDY=0 after third accept, OCC=3; raise O_RDY with I_VLD=1, I=0x44 -> 0x11 out and 0x44 in same edge.
REQ-032 Random I_VLD/O_RDY (50%) for 1000 words -> scoreboard order match, OCC equals model count every cycle.
REQ-033 Assert RST for one cycle with 2 words in flight -> O_VLD=0, OCC=0 next cycle, neither word ever appears.
REQ-034 Rebuild with DEPTH=1 and without PIPEBOX_OCC_EN -> word 0x5A accepted at edge t on O at t, back-to-back throughput 1/cycle, no OCC port.
